uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// requesters and guards each transfer with a watchdog timer.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ack,
  output logic [N_REQ-1:0]         req_done,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     err_timeout
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE        = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t            state_q;
  logic [GW-1:0]     rr_q;
  logic [GW-1:0]     grant_q;
  logic [7:0]        tx_data_q;
  logic [TW-1:0]     timer_q;
  logic              tx_start_q;
  logic [N_REQ-1:0]  ack_q;
  logic [N_REQ-1:0]  done_q;
  logic              active_q;
  logic              err_q;

  logic              win_vld_d;
  logic [GW-1:0]     win_idx_d;
  logic [GW-1:0]     rr_next_d;
  int                scan_s;
  logic [GW-1:0]     scan_idx;

  // Scan downward so the lowest offset from rr_q is the last (winning) assignment.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    scan_s    = 0;
    scan_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_s = int'(rr_q) + k;
      if (scan_s >= N_REQ) scan_s = scan_s - N_REQ;
      scan_idx = GW'(scan_s);
      if (req[scan_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_idx;
      end
    end
  end

  assign rr_next_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d && !tx_busy) begin
            state_q    <= START;
            grant_q    <= win_idx_d;
            tx_data_q  <= req_data[{win_idx_d, 3'b000} +: 8];
            tx_start_q <= 1'b1;
            ack_q      <= ONE << win_idx_d;
            active_q   <= 1'b1;
          end
        end
        START: begin
          state_q <= WAIT_DONE;
          timer_q <= '0;
        end
        WAIT_DONE: begin
          // A done pulse in the final timer cycle still completes normally.
          if (tx_done) begin
            done_q   <= ONE << grant_q;
            rr_q     <= rr_next_d;
            state_q  <= IDLE;
            active_q <= 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            err_q    <= 1'b1;
            rr_q     <= rr_next_d;
            state_q  <= IDLE;
            active_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack     = ack_q;
  assign req_done    = done_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [7:0]     dat [N];
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_done;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b0;
  logic [1:0]     grant_id;
  logic           active;
  logic           err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int rr      = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
  end

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  // First requester at or after the pointer, wrapping around.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_tx_start"}, tx_start, 0);
    chk({pfx, "_req_ack"}, req_ack, 0);
    chk({pfx, "_req_done"}, req_done, 0);
    chk({pfx, "_active"}, active, 0);
    chk({pfx, "_err_timeout"}, err_timeout, 0);
    chk({pfx, "_grant_id"}, grant_id, 0);
    chk({pfx, "_tx_data"}, tx_data, 0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    tx_done = 1'b0;
    tx_busy = 1'b0;
    #2;
    chk_all_zero("rst");
    tick();
    reset = 1'b0;
    rr    = 0;
  endtask

  task automatic do_xfer(input logic [N-1:0] r, input int busy_cyc, input int delay,
                         input bit scramble);
    int w;
    logic [7:0] b;
    req = r;
    w   = pick(r, rr);
    b   = dat[w];
    if (busy_cyc > 0) begin
      tx_busy = 1'b1;
      repeat (busy_cyc) begin
        tick();
        chk("busy_no_start", tx_start, 0);
        chk("busy_not_active", active, 0);
      end
      tx_busy = 1'b0;
    end
    tick();
    chk("start", tx_start, 1);
    chk("ack", req_ack, 32'(1 << w));
    chk("tx_data", tx_data, b);
    chk("grant_id", grant_id, w);
    chk("active", active, 1);
    if (scramble) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
    end
    tx_done = 1'($urandom_range(0, 1));
    tick();
    tx_done = 1'b0;
    chk("start_one_cycle", tx_start, 0);
    chk("ack_one_cycle", req_ack, 0);
    chk("done_in_start_ignored", req_done, 0);
    repeat (delay) begin
      tick();
      chk("tx_data_hold", tx_data, b);
      chk("wait_active", active, 1);
      chk("wait_no_done", req_done, 0);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("req_done", req_done, 32'(1 << w));
    chk("done_inactive", active, 0);
    chk("done_no_timeout", err_timeout, 0);
    chk("done_no_start", tx_start, 0);
    rr = (w + 1) % N;
  endtask

  task automatic do_timeout(input logic [N-1:0] r);
    int w;
    req = r;
    w   = pick(r, rr);
    tick();
    chk("to_start", tx_start, 1);
    chk("to_grant", grant_id, w);
    req = '0;
    tick();
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("to_early", err_timeout, 0);
    end
    tick();
    chk("to_pulse", err_timeout, 1);
    chk("to_no_done", req_done, 0);
    chk("to_inactive", active, 0);
    tick();
    chk("to_one_cycle", err_timeout, 0);
    rr = (w + 1) % N;
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    do_reset();

    // Single request
    dat[0] = 8'hA5;
    do_xfer(4'b0001, 0, 3, 1'b0);

    // Contention, all requesters held
    do_reset();
    dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
    repeat (5) do_xfer(4'b1111, 0, int'($urandom_range(0, 15)), 1'b0);

    // Fairness between two requesters
    do_reset();
    repeat (4) do_xfer(4'b0101, 0, int'($urandom_range(0, 15)), 1'b0);

    // Done pulse while idle is ignored
    req     = '0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_done_ignored", req_done, 0);
    chk("idle_stays_idle", active, 0);

    // Transmitter busy holds off the grant
    do_xfer(4'b0010, 5, 2, 1'b0);

    // Simultaneous done and timeout
    do_xfer(4'b1111, 0, TO - 1, 1'b0);

    // Timeout, then the pointer has moved past the timed-out requester
    do_timeout(4'b0100);
    do_xfer(4'b1111, 0, 1, 1'b0);

    // Reset during WAIT_DONE
    do_reset();
    dat[2] = 8'h5C;
    req = 4'b0100;
    tick();
    chk("mid_start", tx_start, 1);
    req = '0;
    repeat (3) tick();
    chk("mid_active", active, 1);
    reset = 1'b1;
    #2;
    chk_all_zero("mid_rst");
    tick();
    reset = 1'b0;
    rr    = 0;
    chk("mid_rst_no_done", req_done, 0);
    chk("mid_rst_no_err", err_timeout, 0);
    tick();
    chk("post_rst_no_done", req_done, 0);
    chk("post_rst_no_err", err_timeout, 0);
    dat[3] = 8'hE7;
    do_xfer(4'b1000, 0, 2, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
      do_xfer(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, TO - 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
